// File: rtl/fc_pkg.sv
// Shared types and constants for the FC compute lane accumulator.
`timescale 1ns/1ps
package fc_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} fc_acc_state_t;

    localparam logic [15:0] FP16_ZERO     = 16'h0000;
    localparam int unsigned FP16_SIGN_BIT = 15;
endpackage

// File: rtl/floatAdd16.sv
// Combinational IEEE half-precision adder, round-to-nearest-even, canonical qNaN 7E00.
`timescale 1ns/1ps
module floatAdd16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);
    logic        a_big, eff_sub, nan_a, nan_b, inf_a, inf_b, sticky, up, sgn;
    logic [15:0] x, z;
    logic [4:0]  ex, ez, d;
    logic [13:0] mx, mz, mz_al;
    logic [14:0] sum;
    logic [5:0]  e;
    logic [11:0] mr;

    always_comb begin
        nan_a = (a[14:10] == 5'h1f) && (a[9:0] != 10'd0);
        nan_b = (b[14:10] == 5'h1f) && (b[9:0] != 10'd0);
        inf_a = (a[14:10] == 5'h1f) && (a[9:0] == 10'd0);
        inf_b = (b[14:10] == 5'h1f) && (b[9:0] == 10'd0);

        // x carries the larger magnitude so the subtraction never goes negative
        a_big = (a[14:0] >= b[14:0]);
        x     = a_big ? a : b;
        z     = a_big ? b : a;
        ex    = (x[14:10] == 5'd0) ? 5'd1 : x[14:10];
        ez    = (z[14:10] == 5'd0) ? 5'd1 : z[14:10];
        mx    = {(x[14:10] != 5'd0), x[9:0], 3'b000};
        mz    = {(z[14:10] != 5'd0), z[9:0], 3'b000};
        d     = ex - ez;

        sticky = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (5'(i) < d) sticky = sticky | mz[i];
        end
        mz_al = (mz >> d) | {13'd0, sticky};

        eff_sub = x[15] ^ z[15];
        sum     = eff_sub ? ({1'b0, mx} - {1'b0, mz_al}) : ({1'b0, mx} + {1'b0, mz_al});
        e       = {1'b0, ex};

        // normalise; left shifts stop at the subnormal exponent
        if (sum[14]) begin
            sum = {1'b0, sum[14:2], sum[1] | sum[0]};
            e   = e + 6'd1;
        end else begin
            for (int i = 0; i < 13; i++) begin
                if (!sum[13] && (e > 6'd1)) begin
                    sum = sum << 1;
                    e   = e - 6'd1;
                end
            end
        end

        up = sum[2] & (sum[1] | sum[0] | sum[3]);
        mr = {1'b0, sum[13:3]} + {11'd0, up};
        if (mr[11]) begin
            mr = {1'b0, mr[11:1]};
            e  = e + 6'd1;
        end

        sgn = x[15];
        if (mr == 12'd0) sgn = x[15] & ~eff_sub;

        if (e >= 6'd31) y = {sgn, 5'h1f, 10'd0};
        else            y = {sgn, (mr[10] ? e[4:0] : 5'd0), mr[9:0]};

        if (nan_a || nan_b || (inf_a && inf_b && (a[15] != b[15]))) y = 16'h7E00;
        else if (inf_a)                                             y = a;
        else if (inf_b)                                             y = b;
    end
endmodule

// File: rtl/fc_accumulator.sv
// Per-neuron FP16 accumulator: bias on first chunk, optional ReLU, valid/ready result register.
`timescale 1ns/1ps
module fc_accumulator
    import fc_pkg::*;
#(
    parameter int unsigned DATAWIDTH    = 16,
    parameter int unsigned CHUNK_CNT_W  = 8,
    parameter int unsigned NEURON_CNT_W = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cfg_load,
    input  logic [CHUNK_CNT_W-1:0]  cfg_num_chunks,
    input  logic [NEURON_CNT_W-1:0] cfg_num_neurons,
    input  logic                    cfg_relu_en,
    input  logic                    in_valid,
    input  logic [DATAWIDTH-1:0]    in_psum,
    input  logic [DATAWIDTH-1:0]    in_bias,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [DATAWIDTH-1:0]    out_data,
    output logic [NEURON_CNT_W-1:0] out_index,
    input  logic                    out_ready,
    output logic                    done
);
    fc_acc_state_t           state, state_d;
    logic                    done_d;
    logic [CHUNK_CNT_W-1:0]  num_chunks, chunk_cnt;
    logic [NEURON_CNT_W-1:0] num_neurons, neuron_cnt;
    logic                    relu_en;
    logic [DATAWIDTH-1:0]    acc, add_a, sum, result;
    logic                    accept, first_chunk, last_chunk, last_neuron;

    assign in_ready    = (state == RUN) && !(out_valid && !out_ready);
    assign accept      = in_valid && in_ready;
    assign first_chunk = (chunk_cnt == '0);
    assign last_chunk  = (chunk_cnt == num_chunks - CHUNK_CNT_W'(1));
    assign last_neuron = (neuron_cnt == num_neurons - NEURON_CNT_W'(1));

    // single adder; the first operand switches between bias and running sum
    assign add_a = first_chunk ? in_bias : acc;

    floatAdd16 u_add (
        .a (add_a),
        .b (in_psum),
        .y (sum)
    );

    assign result = (relu_en && sum[FP16_SIGN_BIT]) ? FP16_ZERO : sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            done  <= done_d;
        end
    end

    always_comb begin
        state_d = state;
        done_d  = 1'b0;
        case (state)
            IDLE:    if (cfg_load) state_d = RUN;
            RUN:     if (accept && last_chunk && last_neuron) state_d = DRAIN;
            DRAIN: begin
                if (!out_valid || out_ready) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            num_chunks  <= CHUNK_CNT_W'(1);
            num_neurons <= NEURON_CNT_W'(1);
            relu_en     <= 1'b0;
            chunk_cnt   <= '0;
            neuron_cnt  <= '0;
            acc         <= FP16_ZERO;
            out_valid   <= 1'b0;
            out_data    <= FP16_ZERO;
            out_index   <= '0;
        end else begin
            if ((state == IDLE) && cfg_load) begin
                num_chunks  <= (cfg_num_chunks == '0) ? CHUNK_CNT_W'(1) : cfg_num_chunks;
                num_neurons <= (cfg_num_neurons == '0) ? NEURON_CNT_W'(1) : cfg_num_neurons;
                relu_en     <= cfg_relu_en;
                chunk_cnt   <= '0;
                neuron_cnt  <= '0;
                acc         <= FP16_ZERO;
            end

            if (accept) begin
                if (last_chunk) begin
                    chunk_cnt  <= '0;
                    neuron_cnt <= neuron_cnt + NEURON_CNT_W'(1);
                end else begin
                    chunk_cnt  <= chunk_cnt + CHUNK_CNT_W'(1);
                    acc        <= sum;
                end
            end

            // a new result may replace one that is draining in this same cycle
            if (accept && last_chunk) begin
                out_valid <= 1'b1;
                out_data  <= result;
                out_index <= neuron_cnt;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fc_accumulator.sv
// Scoreboard bench for fc_accumulator: expected results queued at stimulus, popped on output handshake.
`timescale 1ns/1ps
module tb_fc_accumulator;
    import fc_pkg::*;

    typedef struct packed {
        logic [15:0] data;
        logic [9:0]  index;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_load;
    logic [7:0]  cfg_num_chunks;
    logic [9:0]  cfg_num_neurons;
    logic        cfg_relu_en;
    logic        in_valid;
    logic [15:0] in_psum;
    logic [15:0] in_bias;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic [9:0]  out_index;
    logic        out_ready;
    logic        done;

    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    fc_accumulator dut (
        .clk             (clk),
        .reset           (reset),
        .cfg_load        (cfg_load),
        .cfg_num_chunks  (cfg_num_chunks),
        .cfg_num_neurons (cfg_num_neurons),
        .cfg_relu_en     (cfg_relu_en),
        .in_valid        (in_valid),
        .in_psum         (in_psum),
        .in_bias         (in_bias),
        .in_ready        (in_ready),
        .out_valid       (out_valid),
        .out_data        (out_data),
        .out_index       (out_index),
        .out_ready       (out_ready),
        .done            (done)
    );

    // output monitor: every handshake must match the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output data=%h index=%0d (no result expected)", out_data, out_index);
            end else begin
                e = sb.pop_front();
                if ((out_data !== e.data) || (out_index !== e.index)) begin
                    errors++;
                    $display("FAIL output data=%h index=%0d expected data=%h index=%0d",
                             out_data, out_index, e.data, e.index);
                end
            end
        end
        if (done) done_cnt++;
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic configure(input logic [7:0] nc, input logic [9:0] nn, input logic relu);
        cfg_num_chunks  = nc;
        cfg_num_neurons = nn;
        cfg_relu_en     = relu;
        cfg_load        = 1'b1;
        @(posedge clk);
        #1 cfg_load = 1'b0;
    endtask

    task automatic send_chunk(input logic [15:0] bias, input logic [15:0] psum, output int stalls);
        in_valid = 1'b1;
        in_bias  = bias;
        in_psum  = psum;
        stalls   = 0;
        @(negedge clk);
        while (!in_ready && stalls < 100) begin
            stalls++;
            @(negedge clk);
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL accept_timeout in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        while (!done && n < 50) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL done_timeout done=%b required 1", done);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_sb_empty(input string name);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_pending outstanding=%0d required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks += 6;
        if (in_ready  !== 1'b0)  begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        if (done      !== 1'b0)  begin errors++; $display("FAIL reset_done got %b want 0", done); end
        if (out_data  !== 16'h0) begin errors++; $display("FAIL reset_out_data got %h want 0000", out_data); end
        if (out_index !== 10'd0) begin errors++; $display("FAIL reset_out_index got %0d want 0", out_index); end
        if (dut.state !== IDLE)  begin errors++; $display("FAIL reset_state got %0d want IDLE", dut.state); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int st;
        configure(8'd3, 10'd1, 1'b0);
        sb.push_back('{16'h4480, 10'd0});
        send_chunk(16'h3C00, 16'h3C00, st);
        send_chunk(16'h7C00, 16'h4000, st);   // bias ignored after first chunk
        send_chunk(16'h7C00, 16'h3800, st);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency out_valid=%b want 1", out_valid); end
        @(negedge clk);
        @(negedge clk);
        checks += 2;
        if (done !== 1'b1)      begin errors++; $display("FAIL basic_done got %b want 1", done); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_done_out_valid got %b want 0", out_valid); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0)      begin errors++; $display("FAIL basic_done_pulse got %b want 0", done); end
        check_sb_empty("basic");
        @(posedge clk);
        #1;
    endtask

    task automatic test_relu();
        int st;
        configure(8'd1, 10'd1, 1'b1);
        sb.push_back('{16'h0000, 10'd0});
        send_chunk(16'hBC00, 16'hC000, st);
        wait_done();
        configure(8'd1, 10'd1, 1'b0);
        sb.push_back('{16'hC200, 10'd0});
        send_chunk(16'hBC00, 16'hC000, st);
        wait_done();
        configure(8'd1, 10'd1, 1'b1);
        sb.push_back('{16'h0000, 10'd0});   // -0 is clamped as well
        send_chunk(16'h8000, 16'h8000, st);
        wait_done();
        check_sb_empty("relu");
    endtask

    task automatic test_backpressure();
        int st;
        configure(8'd1, 10'd2, 1'b0);
        out_ready = 1'b0;
        sb.push_back('{16'h4000, 10'd0});
        sb.push_back('{16'h4400, 10'd1});
        send_chunk(16'h3C00, 16'h3C00, st);
        in_valid = 1'b1;
        in_bias  = 16'h4000;
        in_psum  = 16'h4000;
        repeat (3) begin
            @(negedge clk);
            checks += 3;
            if (in_ready !== 1'b0)   begin errors++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
            if (out_valid !== 1'b1)  begin errors++; $display("FAIL bp_out_valid got %b want 1", out_valid); end
            if (out_data !== 16'h4000) begin errors++; $display("FAIL bp_hold got %h want 4000", out_data); end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_done();
        check_sb_empty("backpressure");
    endtask

    task automatic test_reset_midpass();
        int st;
        configure(8'd4, 10'd1, 1'b0);
        send_chunk(16'h3C00, 16'h4000, st);
        send_chunk(16'h3C00, 16'h4000, st);
        do_reset();
        @(negedge clk);
        checks += 3;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid got %b want 0", out_valid); end
        if (in_ready !== 1'b0)  begin errors++; $display("FAIL midreset_in_ready got %b want 0", in_ready); end
        if (dut.state !== IDLE) begin errors++; $display("FAIL midreset_state got %0d want IDLE", dut.state); end
        @(posedge clk);
        #1;
        configure(8'd1, 10'd1, 1'b0);
        sb.push_back('{16'h4400, 10'd0});
        send_chunk(16'h0000, 16'h4400, st);
        wait_done();
        check_sb_empty("midreset");
    endtask

    task automatic test_cfg_edges();
        int st;
        int d0;
        d0 = done_cnt;
        configure(8'd0, 10'd0, 1'b0);
        sb.push_back('{16'h4200, 10'd0});
        send_chunk(16'h3C00, 16'h4000, st);
        wait_done();
        checks++;
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL cfg_zero_done got %0d want 1", done_cnt - d0); end
        check_sb_empty("cfg_zero");

        // a reload attempt while running must not change chunks/neurons
        configure(8'd2, 10'd1, 1'b0);
        configure(8'd1, 10'd3, 1'b1);
        sb.push_back('{16'h4200, 10'd0});
        send_chunk(16'h3C00, 16'hBC00, st);   // 1 + -1 = 0, then +3 -> 3? no: running sum 0 + 4200
        send_chunk(16'h3C00, 16'h4200, st);
        wait_done();
        repeat (3) @(negedge clk);
        check_sb_empty("cfg_run");
        checks++;
        if (dut.state !== IDLE) begin errors++; $display("FAIL cfg_run_state got %0d want IDLE", dut.state); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_streaming();
        int st;
        int stalls;
        int d0;
        logic [15:0] ps [4];
        ps[0] = 16'h3C00; ps[1] = 16'h4000; ps[2] = 16'h4200; ps[3] = 16'h4400;
        d0 = done_cnt;
        stalls = 0;
        out_ready = 1'b1;
        configure(8'd1, 10'd4, 1'b0);
        for (int i = 0; i < 4; i++) sb.push_back('{ps[i], 10'(i)});
        for (int i = 0; i < 4; i++) begin
            send_chunk(16'h0000, ps[i], st);
            stalls += st;
        end
        checks++;
        if (stalls != 0) begin errors++; $display("FAIL stream_stalls got %0d want 0", stalls); end
        wait_done();
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL stream_done_count got %0d want 1", done_cnt - d0); end
        check_sb_empty("stream");
    endtask

    initial begin
        reset           = 1'b1;
        cfg_load        = 1'b0;
        cfg_num_chunks  = 8'd0;
        cfg_num_neurons = 10'd0;
        cfg_relu_en     = 1'b0;
        in_valid        = 1'b0;
        in_psum         = 16'h0;
        in_bias         = 16'h0;
        out_ready       = 1'b1;

        test_reset();
        test_basic();
        test_relu();
        test_backpressure();
        test_reset_midpass();
        test_cfg_edges();
        test_streaming();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
